// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional feature macro used by this slice: MD_EARLY_OUT_EN.
package md_pkg;

  localparam int MD_XLEN = 32;
  localparam int MD_ITER = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Codes 0..3 are the iterative multiply/divide operations.
  function automatic logic md_is_arith(input logic [2:0] code);
    return (code[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_if.sv
// Bus between the ID/EX stage and the multiply/divide unit.
interface md_if
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
);

  logic            start;
  logic [2:0]      md_control;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] result;

  modport master (
    output start, md_control, a, b,
    input  busy, hi, lo, result
  );

  modport slave (
    input  start, md_control, a, b,
    output busy, hi, lo, result
  );

endinterface

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module md_step
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] opnd_i,
  input  logic [XLEN-1:0]   mplr_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [2*XLEN-1:0] opnd_o,
  output logic [XLEN-1:0]   mplr_o
);

  // In divide mode acc holds {remainder, dividend/quotient}; the trial needs one extra bit.
  logic [2*XLEN:0] shl_s;
  logic [XLEN:0]   trial_s;
  logic [XLEN-1:0] diff_s;

  assign shl_s   = {acc_i, 1'b0};
  assign trial_s = shl_s[2*XLEN:XLEN];
  assign diff_s  = trial_s[XLEN-1:0] - opnd_i[XLEN-1:0];

  // Next accumulator and shifted operands for the selected mode.
  always_comb begin
    acc_o  = acc_i;
    opnd_o = opnd_i;
    mplr_o = mplr_i;
    if (div_i) begin
      if (trial_s >= {1'b0, opnd_i[XLEN-1:0]}) begin
        acc_o = {diff_s, shl_s[XLEN-1:1], 1'b1};
      end else begin
        acc_o = shl_s[2*XLEN-1:0];
      end
    end else begin
      if (mplr_i[0]) begin
        acc_o = acc_i + opnd_i;
      end else begin
        acc_o = acc_i;
      end
      opnd_o = opnd_i << 1;
      mplr_o = mplr_i >> 1;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning HI/LO; busy stalls the front end.
// Optional MD_EARLY_OUT_EN: multiplies retire once the multiplier is exhausted.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int ITER = MD_ITER
) (
  input  logic clock,
  input  logic reset,
  md_if.slave  bus
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              neg_q, neg_d;
  logic              sa_q, sa_d;
  logic              dz_q, dz_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0]   mplr_q, mplr_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              is_div_s;
  logic              sgn_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              last_s;
  logic [2*XLEN-1:0] step_acc_s;
  logic [2*XLEN-1:0] step_opnd_s;
  logic [XLEN-1:0]   step_mplr_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;

  assign is_div_s = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign sgn_s    = ~bus.md_control[0];
  assign a_neg_s  = sgn_s & bus.a[XLEN-1];
  assign b_neg_s  = sgn_s & bus.b[XLEN-1];
  assign a_mag_s  = a_neg_s ? (~bus.a + {{(XLEN-1){1'b0}}, 1'b1}) : bus.a;
  assign b_mag_s  = b_neg_s ? (~bus.b + {{(XLEN-1){1'b0}}, 1'b1}) : bus.b;

  md_step #(.XLEN(XLEN)) u_step (
    .div_i  (is_div_s),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .mplr_i (mplr_q),
    .acc_o  (step_acc_s),
    .opnd_o (step_opnd_s),
    .mplr_o (step_mplr_s)
  );

  // Sign fix-up on magnitudes; neg_q/sa_q are already cleared for unsigned ops.
  assign prod_s = neg_q ? (~step_acc_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : step_acc_s;
  assign quot_s = neg_q ? (~step_acc_s[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                        : step_acc_s[XLEN-1:0];
  assign rem_s  = sa_q ? (~step_acc_s[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                       : step_acc_s[2*XLEN-1:XLEN];

  // Final-iteration detection, including the optional multiply early-out.
  always_comb begin
    last_s = (cnt_q == LAST);
`ifdef MD_EARLY_OUT_EN
    if (!is_div_s && (step_mplr_s == {XLEN{1'b0}})) begin
      last_s = 1'b1;
    end else begin
      last_s = (cnt_q == LAST);
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mplr_d  = mplr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (md_is_arith(bus.md_control)) begin
            op_d    = md_op_e'(bus.md_control);
            cnt_d   = {CW{1'b0}};
            neg_d   = a_neg_s ^ b_neg_s;
            sa_d    = a_neg_s;
            dz_d    = (bus.b == {XLEN{1'b0}});
            state_d = RUN;
            if (bus.md_control[1]) begin
              acc_d  = {{XLEN{1'b0}}, a_mag_s};
              opnd_d = {{XLEN{1'b0}}, b_mag_s};
              mplr_d = {XLEN{1'b0}};
            end else begin
              acc_d  = {(2*XLEN){1'b0}};
              opnd_d = {{XLEN{1'b0}}, a_mag_s};
              mplr_d = b_mag_s;
            end
          end else if (bus.md_control == MD_MTHI) begin
            hi_d = bus.a;
          end else if (bus.md_control == MD_MTLO) begin
            lo_d = bus.a;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = step_acc_s;
        opnd_d = step_opnd_s;
        mplr_d = step_mplr_s;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (last_s) begin
          state_d = IDLE;
          if (is_div_s) begin
            lo_d = dz_q ? {XLEN{1'b1}} : quot_s;
            hi_d = rem_s;
          end else begin
            lo_d = prod_s[XLEN-1:0];
            hi_d = prod_s[2*XLEN-1:XLEN];
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= {(2*XLEN){1'b0}};
      opnd_q  <= {(2*XLEN){1'b0}};
      mplr_q  <= {XLEN{1'b0}};
      hi_q    <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      mplr_q  <= mplr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = (bus.md_control == MD_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/busy length queued at issue, checked at retire.
module tb_md_unit;
  import md_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  md_if #(.XLEN(32)) bus();

  md_unit #(.XLEN(32), .ITER(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mhi = 32'h0;
  logic [31:0] mlo = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from native arithmetic; updates the model HI/LO.
  task automatic push_expected(input string tag, input md_op_e op,
                               input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sx, sy;
    logic [63:0] p;
    int          sa, sb;
    e.tag = tag; e.hi = mhi; e.lo = mlo; e.cycles = 32;
    sa = a; sb = b;
    case (op)
      MD_MULT: begin
        sx = longint'(sa); sy = longint'(sb); p = sx * sy;
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      MD_DIV: begin
        if (b == 32'h0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'h0;
        end else begin
          e.lo = sa / sb; e.hi = sa % sb;
        end
      end
      MD_DIVU: begin
        if (b == 32'h0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      MD_MTHI: begin e.hi = a; e.cycles = 0; end
      MD_MTLO: begin e.lo = a; e.cycles = 0; end
      default: e.cycles = 0;
    endcase
`ifdef MD_EARLY_OUT_EN
    if (op == MD_MULT || op == MD_MULTU) begin
      logic [31:0] mag;
      mag = (op == MD_MULT && b[31]) ? -b : b;
      e.cycles = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) e.cycles = i + 1;
    end
`endif
    mhi = e.hi; mlo = e.lo;
    sb_q.push_back(e);
  endtask

  task automatic run_op(input string tag, input md_op_e op,
                        input logic [31:0] a, input logic [31:0] b, input bit inject);
    exp_t        e;
    int          cyc;
    logic [31:0] hi0, lo0;
    hi0 = mhi; lo0 = mlo; cyc = 0;
    push_expected(tag, op, a, b);
    @(negedge clock);
    bus.start = 1'b1; bus.md_control = op; bus.a = a; bus.b = b;
    @(negedge clock);
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 1) begin
        check_eq({tag, "_hold_hi"}, bus.hi, hi0);
        check_eq({tag, "_hold_lo"}, bus.lo, lo0);
      end
      if (inject && cyc == 5) begin
        bus.start = 1'b1; bus.md_control = MD_MTLO; bus.a = 32'd9;
      end
      if (inject && cyc == 6) begin
        bus.start = 1'b0;
        check_eq({tag, "_ignored_mtlo"}, bus.lo, lo0);
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    e = sb_q.pop_front();
    check_eq({e.tag, "_cycles"}, 32'(cyc), 32'(e.cycles));
    check_eq({e.tag, "_hi"}, bus.hi, e.hi);
    check_eq({e.tag, "_lo"}, bus.lo, e.lo);
  endtask

  task automatic run_mt(input string tag, input md_op_e op, input logic [31:0] a);
    exp_t e;
    push_expected(tag, op, a, 32'h0);
    @(negedge clock);
    bus.start = 1'b1; bus.md_control = op; bus.a = a;
    @(negedge clock);
    bus.start = 1'b0;
    e = sb_q.pop_front();
    check_eq({e.tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
    check_eq({e.tag, "_hi"}, bus.hi, e.hi);
    check_eq({e.tag, "_lo"}, bus.lo, e.lo);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.md_control = 3'd0; bus.a = 32'h0; bus.b = 32'h0;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
    check_eq("rst_hi", bus.hi, 32'h0);
    check_eq("rst_lo", bus.lo, 32'h0);
    reset = 1'b0;

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("multu_max_hi_const", bus.hi, 32'hFFFF_FFFE);
    check_eq("multu_max_lo_const", bus.lo, 32'h0000_0001);

    run_op("mult_m3x7", MD_MULT, -32'sd3, 32'd7, 1'b0);
    bus.md_control = MD_MFLO;
    #1 check_eq("mflo_result", bus.result, 32'hFFFF_FFEB);
    bus.start = 1'b1; bus.md_control = MD_MFHI;
    #1 check_eq("mfhi_result", bus.result, 32'hFFFF_FFFF);
    @(negedge clock);
    bus.start = 1'b0;
    check_eq("mfhi_start_busy", {31'h0, bus.busy}, 32'h0);
    check_eq("mfhi_start_hi", bus.hi, mhi);
    check_eq("mfhi_start_lo", bus.lo, mlo);

    run_op("div_m7_2", MD_DIV, -32'sd7, 32'd2, 1'b0);
    check_eq("div_m7_2_lo_const", bus.lo, 32'hFFFF_FFFD);
    run_op("divu_by0", MD_DIVU, 32'd100, 32'd0, 1'b0);
    check_eq("divu_by0_lo_const", bus.lo, 32'hFFFF_FFFF);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg_by0", MD_DIV, -32'sd100, 32'd0, 1'b0);
    run_op("div_m9_m4", MD_DIV, -32'sd9, -32'sd4, 1'b0);
    run_op("mult_b0", MD_MULT, 32'h1234_5678, 32'd0, 1'b0);
    run_op("eo_3x2", MD_MULTU, 32'd3, 32'd2, 1'b0);
    check_eq("eo_3x2_lo_const", bus.lo, 32'd6);

    for (int i = 0; i < 6; i++) begin
      md_op_e      op;
      logic [31:0] ra, rb;
      op = md_op_e'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
      if (i == 3) rb = -rb;
      run_op($sformatf("rand%0d", i), op, ra, rb, 1'b0);
    end

    run_op("multu_inject", MD_MULTU, 32'd6, 32'h8000_0007, 1'b1);
    run_mt("mtlo", MD_MTLO, 32'hCAFE_0001);

    // Reset in the middle of a divide.
    @(negedge clock);
    bus.start = 1'b1; bus.md_control = MD_DIVU; bus.a = 32'd50; bus.b = 32'd7;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    check_eq("mid_busy_before_rst", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    check_eq("mid_rst_hi", bus.hi, 32'h0);
    check_eq("mid_rst_lo", bus.lo, 32'h0);
    mhi = 32'h0; mlo = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    run_mt("mthi_after_rst", MD_MTHI, 32'd5);

    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Iterative multiply/divide unit in the EX stage. It consumes the ID/EX start/md_control/operand fields and owns the architectural HI/LO registers. It drives the pipeline stall2 input while an operation runs, so the front end holds until HI/LO are final.
MULT/MULTU use radix-2 shift-add; DIV/DIVU use radix-2 restoring division on magnitudes with a final sign fix-up.

Parameters:
XLEN, 32, operand/HI/LO width
ITER, 32, iterations per mult/div (must equal XLEN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  EX_start qualifier; launches op in md_control
md_control  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO
a  in  XLEN  rs operand (forwarded)
b  in  XLEN  rt operand (forwarded)
busy  out  1  operation in progress; wired to stall2
hi  out  XLEN  HI register
lo  out  XLEN  LO register
result  out  XLEN  md_control==4 ? hi : lo (combinational, for MFHI/MFLO writeback)

Behaviour:
- Interface: reset is asynchronous and active-high; the clock is clock.
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, busy=0, hi=0, lo=0, counter=0, operand latches=0.
  - The in-flight result is discarded.
- States: IDLE, RUN. busy = (state==RUN), registered.
- Accept:
  - Condition: IDLE and start and md_control in 0..3.
  - On that edge: latch |a|, |b| (signed ops) or raw a, b (unsigned ops); latch the sign flags and op; counter←0; state←RUN.
- RUN: one iteration per edge, counter++.
  - On the edge with counter==ITER-1: the final iteration completes, sign fix-up is applied, hi/lo are written, state←IDLE.
  - busy is high for exactly ITER (32) cycles. hi/lo hold their old values until that final edge.
- Multiply: 64-bit product; hi=product[63:32], lo=product[31:0]. Signed ops negate the 64-bit product when the operand signs differ.
- Divide: lo=quotient, hi=remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero (signed or unsigned): still takes 32 cycles; lo=0xFFFFFFFF, hi=a.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: IDLE and start → hi←a or lo←a on that edge, no busy.
- MFHI/MFLO: no state change; result is valid whenever busy=0.
- start while busy=1: ignored for every op. The stalled pipeline re-presents the op later.
- start with md_control 4/5: no effect on state.

Optional Feature:
MD_EARLY_OUT_EN
- Defined: MULT/MULTU finish early when the remaining unshifted multiplier bits are all zero. The final write happens on that edge and busy drops; minimum 1 busy cycle (b==0 → 1 cycle). Divide is unaffected.
- Undefined: every mult/div takes exactly 32 busy cycles.

Decomposition:
- md_pkg holds:
  - the md_op_e enum (8 codes above);
  - MD_ITER=32;
  - state enum md_state_e {IDLE, RUN}.
- Sub-module md_step: combinational single iteration. Inputs are the accumulator/remainder, multiplicand/divisor and mode; output is the next accumulator/remainder and the shifted operand. It is instantiated once in md_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy 32 cycles, then hi=0xFFFFFFFE lo=0x00000001.
- MULT a=-3 b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB; result=lo with md_control=5, hi with md_control=4.
- DIV a=-7 b=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=100 b=0 → lo=0xFFFFFFFF hi=100 after 32 cycles.
- DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000 hi=0.
- Start DIVU 50/7; assert reset at busy cycle 10 → busy=0 hi=lo=0 immediately. Next MTHI a=5 → hi=5 next edge.
- During MULTU busy, start MTLO a=9 → ignored, lo unchanged until completion. With MD_EARLY_OUT_EN, MULTU 3*2 → busy ≤2 cycles, lo=6.
